// File: rtl/tone_meter.sv
// Single-tone frequency/amplitude meter: counts samples over 2^NCYC_LOG2 rising
// crossings and divides to a DDS tuning word. Define TONE_METER_AMPL_EN to build the amplitude path.
module tone_meter #(
  parameter int DAC_WIDTH = 12,
  parameter int NCYC_LOG2 = 2,
  parameter int HYST      = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adc_valid,
  input  logic [DAC_WIDTH-1:0] adc_data,
  output logic [28:1]          Freq_KW,
  output logic [DAC_WIDTH-1:0] Ampl_out,
  output logic                 meas_valid,
  output logic                 timeout,
  output logic                 busy
);

  // state        | meaning
  // S_WAIT_FIRST | looking for the first rising crossing
  // S_MEASURE    | counting samples until N more crossings
  // S_LOAD       | one entry cycle that seeds the divider
  // S_DIVIDE     | 28 restoring-division steps, samples ignored
  // S_DONE       | register results, strobe meas_valid
  typedef enum logic [2:0] {
    S_WAIT_FIRST, S_MEASURE, S_LOAD, S_DIVIDE, S_DONE
  } state_t;

  localparam int                      L_QBITS = 28;
  localparam int                      L_MID   = 2 ** (DAC_WIDTH - 1);
  localparam logic signed [DAC_WIDTH:0] L_HYST = (DAC_WIDTH + 1)'(HYST);
  localparam logic [NCYC_LOG2:0]      L_N     = (NCYC_LOG2 + 1)'(2 ** NCYC_LOG2);
  localparam logic [CNT_WIDTH-1:0]    L_TC_M1 = {{(CNT_WIDTH - 1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0]    L_REM0  = CNT_WIDTH'(2 ** NCYC_LOG2);

  state_t                 r_state;
  logic                   r_arm;
  logic                   r_to;
  logic [CNT_WIDTH-1:0]   r_tcnt;
  logic [CNT_WIDTH-1:0]   r_s;
  logic [NCYC_LOG2:0]     r_ncross;
  logic [CNT_WIDTH-1:0]   r_rem;
  logic [L_QBITS-1:0]     r_q;
  logic [4:0]             r_it;

  logic signed [DAC_WIDTH:0] w_x;
  logic                      w_below;
  logic                      w_cross;
  logic                      w_tc;
  logic [CNT_WIDTH:0]        w_rem2;
  logic                      w_ge;
  logic [CNT_WIDTH-1:0]      w_sub;

  assign w_x     = $signed({1'b0, adc_data}) - $signed((DAC_WIDTH + 1)'(L_MID));
  assign w_below = (w_x < -L_HYST);
  assign w_cross = r_arm && (w_x >= L_HYST);
  // r_tcnt saturates, so this also holds once the terminal count is reached
  assign w_tc    = (r_tcnt >= L_TC_M1);
  assign w_rem2  = {r_rem, 1'b0};
  assign w_ge    = (w_rem2 >= {1'b0, r_s});
  assign w_sub   = w_rem2[CNT_WIDTH-1:0] - r_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_WAIT_FIRST;
      r_arm      <= 1'b0;
      r_to       <= 1'b0;
      r_tcnt     <= '0;
      r_s        <= '0;
      r_ncross   <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_it       <= '0;
      Freq_KW    <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (r_state)
        S_WAIT_FIRST: begin
          if (adc_valid) begin
            if (r_tcnt != '1) r_tcnt <= r_tcnt + 1'b1;
            if (w_below) r_arm <= 1'b1;
            if (w_cross) begin
              r_arm    <= 1'b0;
              r_s      <= '0;
              r_ncross <= '0;
              r_state  <= S_MEASURE;
            end else if (w_tc) begin
              r_to    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_MEASURE: begin
          if (adc_valid) begin
            if (r_tcnt != '1) r_tcnt <= r_tcnt + 1'b1;
            r_s <= r_s + 1'b1;
            if (w_below) r_arm <= 1'b1;
            if (w_cross) begin
              r_arm    <= 1'b0;
              r_ncross <= r_ncross + 1'b1;
              if (r_ncross == L_N - 1'b1) r_state <= S_LOAD;
            end else if (w_tc) begin
              r_to    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          // dividend 2^(28+NCYC_LOG2): the upper 2^NCYC_LOG2 seeds the remainder
          r_rem   <= L_REM0;
          r_it    <= '0;
          busy    <= 1'b1;
          r_state <= S_DIVIDE;
        end
        S_DIVIDE: begin
          r_rem <= w_ge ? w_sub : w_rem2[CNT_WIDTH-1:0];
          r_q   <= {r_q[L_QBITS-2:0], w_ge};
          r_it  <= r_it + 1'b1;
          if (r_it == 5'(L_QBITS - 1)) begin
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          meas_valid <= 1'b1;
          timeout    <= r_to;
          Freq_KW    <= r_to ? '0 : r_q;
          r_to       <= 1'b0;
          r_arm      <= 1'b0;
          r_tcnt     <= '0;
          r_state    <= S_WAIT_FIRST;
        end
        default: r_state <= S_WAIT_FIRST;
      endcase
    end
  end

`ifdef TONE_METER_AMPL_EN
  logic [DAC_WIDTH-1:0] r_max;
  logic [DAC_WIDTH-1:0] r_min;
  logic [DAC_WIDTH-1:0] r_ampl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max  <= '0;
      r_min  <= '0;
      r_ampl <= '0;
    end else begin
      if (r_state == S_WAIT_FIRST && adc_valid && w_cross) begin
        r_max <= adc_data;
        r_min <= adc_data;
      end else if (r_state == S_MEASURE && adc_valid) begin
        if (adc_data > r_max) r_max <= adc_data;
        if (adc_data < r_min) r_min <= adc_data;
      end
      if (r_state == S_DONE) r_ampl <= r_to ? '0 : ((r_max - r_min) >> 1);
    end
  end

  assign Ampl_out = r_ampl;
`else
  assign Ampl_out = '0;
`endif

endmodule

// File: doc/tone_meter.md
# tone_meter

Measures the frequency and amplitude of a sampled single tone and returns them in DDS units. It sits on the ADC side of the loop and is the inverse of the DDS generator. It converts an offset-binary sample stream into a 28-bit phase-increment tuning word, `Freq_KW`, which can be fed straight back to a DDS. It also produces a half peak-to-peak amplitude estimate, which serves loopback self-test and tone tracking.

## Interface
- `DAC_WIDTH`, 12 — sample width in bits; offset binary, midscale 2^(DAC_WIDTH-1).
- `NCYC_LOG2`, 2 — number of periods averaged per measurement, N = 2^NCYC_LOG2.
- `HYST`, 64 — hysteresis half-width in LSBs around midscale.
- `CNT_WIDTH`, 16 — width of the sample counter and the timeout counter.
- `clk` input 1 — single clock.
- `rst_n` input 1 — reset, synchronous, active-low.
- `adc_valid` input 1 — qualifies `adc_data` for one cycle.
- `adc_data` input DAC_WIDTH — ADC sample.
- `Freq_KW` output [28:1] — measured tuning word.
- `Ampl_out` output DAC_WIDTH — amplitude estimate, (max−min)>>1.
- `meas_valid` output 1 — one-cycle strobe; results are valid on this cycle and held until the next strobe.
- `timeout` output 1 — qualifies `meas_valid`; set when no tone was found.
- `busy` output 1 — high in DIVIDE.

## Operation
- Signed sample: x = adc_data − 2^(DAC_WIDTH−1). Only samples with `adc_valid` = 1 are processed.
- Arm flag: set when x < −HYST.
- Crossing: armed and x ≥ +HYST. A crossing clears the arm flag. It is a rising crossing only.
- State machine:
  - WAIT_FIRST:
    - The timeout counter increments per valid sample.
    - On a crossing: sample counter S := 0, crossing count := 0, max = min = that sample; go to MEASURE.
  - MEASURE:
    - Each valid sample increments S and the timeout counter, and updates max/min.
    - On a crossing, the crossing count increments. When it reaches N (the crossing sample is counted in S), go to DIVIDE.
  - Timeout: if the timeout counter reaches 2^CNT_WIDTH−1 in WAIT_FIRST or MEASURE, go to DONE with `timeout` = 1.
  - DIVIDE:
    - Sequential restoring division Q = floor(2^(28+NCYC_LOG2) / S), one quotient bit per clock, 28 iterations.
    - Valid samples are ignored.
  - DONE:
    - Register results and pulse `meas_valid` for one cycle.
    - Clear the arm flag and the timeout counter, then return to WAIT_FIRST.
- Hysteresis forces S ≥ 2N, so Q ≤ 2^27. `Freq_KW` never saturates.
- On timeout: `Freq_KW` = 0 and `Ampl_out` = 0.
- Reset while in any state:
  - Return to WAIT_FIRST.
  - Discard the measurement in progress; no `meas_valid` is produced.
  - Clear all outputs.

## Timing
- Reset values:
  - `Freq_KW` = 0, `Ampl_out` = 0, `meas_valid` = 0, `timeout` = 0, `busy` = 0.
  - State = WAIT_FIRST; arm flag, S, crossing count, max/min, and timeout counter all cleared.
- Latency: `meas_valid` rises exactly 30 clocks after the edge that samples the N-th crossing. That is 1 cycle of entry, 28 division cycles and 1 DONE cycle.
- `busy` is high for exactly 28 cycles.
- Timeout path: `meas_valid` rises 1 clock after the edge that sampled the terminal timeout count.
- When a crossing and the timeout terminal count coincide on the same sample, the crossing wins.
- `adc_valid` may be asserted every cycle or sparsely. Only valid samples advance any counter; the divider advances every clock.

## Configuration
- `TONE_METER_AMPL_EN`
  - Defined: max/min trackers and the `Ampl_out` register are built as described.
  - Undefined: trackers are removed and `Ampl_out` is tied to 0. `Freq_KW`, `meas_valid` and `timeout` timing are unchanged.

## Test plan
All scenarios use DAC_WIDTH=12, NCYC_LOG2=2, HYST=64 and CNT_WIDTH=16, with `adc_valid` high every cycle unless stated otherwise.
- Square wave, 8 samples at 3000 then 8 at 1000 (period 16), repeated:
  - `meas_valid` pulses with `Freq_KW` = 16777216 (2^24), `Ampl_out` = 1000, `timeout` = 0.
  - The strobe comes 30 clocks after the 4th counted crossing and repeats for every measurement.
- Same waveform with `adc_valid` high one cycle in three: same `Freq_KW` and `Ampl_out`.
- Alternate 3000/1000 every sample (period 2): S = 8, `Freq_KW` = 134217728 (2^27).
- Noise of ±50 around 2048 for 70000 samples:
  - No crossings occur.
  - `meas_valid` pulses with `timeout` = 1 and `Freq_KW` = 0 after 65535 samples.
- Pull `rst_n` low for one cycle at the 10th cycle of DIVIDE:
  - No `meas_valid` for that measurement; all outputs are 0 on the next cycle.
  - The next full measurement reports 2^24.
- Build without `TONE_METER_AMPL_EN` and rerun the first scenario: `Freq_KW` = 2^24 and `Ampl_out` = 0.
